// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, data width and baud divider helper.
`timescale 1ns/1ps
package uart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  // Clocks per oversample tick, truncated, never below 1.
  function automatic int calc_div(input int clk_freq, input int baud, input int os);
    int d;
    d = clk_freq / (baud * os);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator; tick is high on the wrap cycle of a 0..DIV-1 counter.
`timescale 1ns/1ps
module uart_baud_tick #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clear || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversampled, mid-bit sampling, valid/ready holding register,
// single-cycle framing-error and overrun pulses.
`timescale 1ns/1ps
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUDRATE   = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              frame_err,
  output logic              overrun
);

  localparam int     DIV     = calc_div(CLK_FREQ, BAUDRATE, OVERSAMPLE);
  localparam longint NOMINAL = longint'(DIV) * longint'(OVERSAMPLE) * longint'(BAUDRATE);
  localparam longint DIFF    = (longint'(CLK_FREQ) >= NOMINAL) ? longint'(CLK_FREQ) - NOMINAL
                                                               : NOMINAL - longint'(CLK_FREQ);
  localparam int     OSW     = $clog2(OVERSAMPLE);
  localparam logic [OSW-1:0] OS_MID = OSW'(OVERSAMPLE / 2 - 1);
  localparam logic [OSW-1:0] OS_END = OSW'(OVERSAMPLE - 1);

  if ((OVERSAMPLE < 8) || (OVERSAMPLE % 2 != 0)) begin : g_os_err
    $error("uart_rx: OVERSAMPLE must be even and at least 8");
  end
  if (DIFF * 50 >= NOMINAL) begin : g_baud_err
    $error("uart_rx: baud divider truncation error is 2%% or more");
  end

  rx_state_t         r_state, w_state_nxt;
  logic [1:0]        r_sync;
  logic              w_rx_s;
  logic              w_tick;
  logic              w_clear;
  logic [OSW-1:0]    r_os_cnt;
  logic              w_mid, w_end;
  logic [2:0]        r_bit_idx;
  logic [DATA_W-1:0] r_shift;
  logic              w_sample_bit, w_deliver, w_stop_bad;

  assign w_rx_s  = r_sync[1];
  assign w_clear = (r_state == IDLE);
  assign w_mid   = w_tick && (r_os_cnt == OS_MID);
  assign w_end   = w_tick && (r_os_cnt == OS_END);

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (w_clear),
    .tick  (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= '1;
      r_state <= IDLE;
    end else begin
      r_sync  <= {r_sync[0], rx};
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_sample_bit = 1'b0;
    w_deliver    = 1'b0;
    w_stop_bad   = 1'b0;
    case (r_state)
      IDLE:  if (!w_rx_s) w_state_nxt = START;
      START: begin
        if (w_mid && w_rx_s) w_state_nxt = IDLE;
        else if (w_end)      w_state_nxt = DATA;
      end
      DATA: begin
        w_sample_bit = w_mid;
        if (w_end && (r_bit_idx == 3'd7)) w_state_nxt = STOP;
      end
      // Leave at the stop-bit midpoint so a shortened stop bit still lets the next frame in.
      STOP: begin
        if (w_mid) begin
          if (w_rx_s) begin
            w_deliver   = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_stop_bad  = 1'b1;
            w_state_nxt = BREAK;
          end
        end
      end
      BREAK:   if (w_rx_s) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_os_cnt  <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      if (r_state == IDLE)  r_os_cnt <= '0;
      else if (w_tick)      r_os_cnt <= (r_os_cnt == OS_END) ? '0 : r_os_cnt + 1'b1;
      if (r_state != DATA)  r_bit_idx <= '0;
      else if (w_end)       r_bit_idx <= r_bit_idx + 3'd1;
      if (w_sample_bit)     r_shift[r_bit_idx] <= w_rx_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= w_stop_bad;
      overrun   <= w_deliver && rx_valid && !rx_ready;
      if (w_deliver && (!rx_valid || rx_ready)) begin
        rx_data  <= r_shift;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames against a queue model.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int BIT_CLKS = 160;
  // Cycles from the start-edge drive to the delivery cycle: 2 sync + 1 state entry
  // + half a bit + 9 full bits, so rx_valid rises on the following edge.
  localparam int DELIVER_CLKS = 2 + 1 + BIT_CLKS / 2 + 9 * BIT_CLKS;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       frame_err;
  logic       overrun;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int         n_fe, n_ov, n_vcyc, n_vfall;
  logic       prev_valid = 1'b0;

  uart_rx #(
    .CLK_FREQ   (1_536_000),
    .BAUDRATE   (9600),
    .OVERSAMPLE (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
      if (frame_err) n_fe++;
      if (overrun) n_ov++;
      if (rx_valid) n_vcyc++;
      if (prev_valid && !rx_valid) n_vfall++;
    end
    prev_valid = rx_valid;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_obs();
    got_q.delete();
    exp_q.delete();
    n_fe = 0; n_ov = 0; n_vcyc = 0; n_vfall = 0;
  endtask

  task automatic check_stream(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk({tag, "_byte"}, (i < got_q.size()) ? {24'h0, got_q[i]} : 'x, {24'h0, exp_q[i]});
  endtask

  // Line is left at the stop-bit level when the task returns.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    @(posedge clk); #1 rx = 1'b0;
    repeat (BIT_CLKS) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rx = b[i];
      repeat (BIT_CLKS) @(posedge clk);
    end
    #1 rx = stop;
    repeat (BIT_CLKS) @(posedge clk);
  endtask

  task automatic idle_bits(input int n);
    repeat (n * BIT_CLKS) @(posedge clk);
  endtask

  task automatic glitch(input int len);
    @(posedge clk); #1 rx = 1'b0;
    repeat (len) @(posedge clk);
    #1 rx = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic       bad;
    int         n_bad;

    repeat (5) @(posedge clk);
    #1;
    chk("rst_data", {24'h0, rx_data}, 32'h0);
    chk("rst_valid", {31'h0, rx_valid}, 32'h0);
    chk("rst_fe", {31'h0, frame_err}, 32'h0);
    chk("rst_ov", {31'h0, overrun}, 32'h0);
    rst_n = 1'b1;
    idle_bits(1);

    // Single byte, consumer always ready
    clear_obs();
    rx_ready = 1'b1;
    send_frame(8'h23, 1'b1);
    idle_bits(1);
    exp_q.push_back(8'h23);
    check_stream("t1");
    chk("t1_vcyc", n_vcyc, 1);
    chk("t1_fe", n_fe, 0);
    chk("t1_ov", n_ov, 0);

    // Overrun: second byte dropped while the first is held
    clear_obs();
    #1 rx_ready = 1'b0;
    send_frame(8'h51, 1'b1);
    send_frame(8'hA5, 1'b1);
    idle_bits(1);
    chk("t2_valid", {31'h0, rx_valid}, 32'h1);
    chk("t2_data", {24'h0, rx_data}, 32'h51);
    chk("t2_ov", n_ov, 1);
    @(posedge clk); #1 rx_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    exp_q.push_back(8'h51);
    check_stream("t2");
    chk("t2_valid_after", {31'h0, rx_valid}, 32'h0);

    // Framing error followed by a break, then a good frame
    clear_obs();
    send_frame(8'h3C, 1'b0);
    idle_bits(3);
    #1 rx = 1'b1;
    idle_bits(1);
    send_frame(8'h7E, 1'b1);
    idle_bits(1);
    exp_q.push_back(8'h7E);
    check_stream("t3");
    chk("t3_fe", n_fe, 1);
    chk("t3_ov", n_ov, 0);

    // Short low glitch is a false start
    clear_obs();
    glitch(40);
    idle_bits(2);
    chk("t4_vcyc", n_vcyc, 0);
    chk("t4_fe", n_fe, 0);
    send_frame(8'h00, 1'b1);
    idle_bits(1);
    exp_q.push_back(8'h00);
    check_stream("t4");

    // Randomized frames, glitches, gaps and bad stop bits
    clear_obs();
    n_bad = 0;
    for (int k = 0; k < 8; k++) begin
      if ($urandom_range(2) == 0) begin
        glitch($urandom_range(60, 10));
        idle_bits(1);
      end
      b   = 8'($urandom);
      bad = ($urandom_range(4) == 0);
      send_frame(b, !bad);
      if (bad) begin
        n_bad++;
        idle_bits(1);
        #1 rx = 1'b1;
        idle_bits(1);
      end else begin
        exp_q.push_back(b);
      end
      idle_bits($urandom_range(2));
    end
    idle_bits(1);
    check_stream("rand");
    chk("rand_fe", n_fe, n_bad);
    chk("rand_ov", n_ov, 0);

    // Reset in the middle of data bit 4 of 0xFF, with a byte pending
    clear_obs();
    #1 rx_ready = 1'b0;
    send_frame(8'h5A, 1'b1);
    idle_bits(1);
    chk("t5_pending", {31'h0, rx_valid}, 32'h1);
    @(posedge clk); #1 rx = 1'b0;
    repeat (BIT_CLKS) @(posedge clk);
    #1 rx = 1'b1;
    repeat (4 * BIT_CLKS + BIT_CLKS / 2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rst_data", {24'h0, rx_data}, 32'h0);
    chk("t5_rst_valid", {31'h0, rx_valid}, 32'h0);
    chk("t5_rst_fe", {31'h0, frame_err}, 32'h0);
    chk("t5_rst_ov", {31'h0, overrun}, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    rx_ready = 1'b1;
    repeat (4 * BIT_CLKS) @(posedge clk);
    idle_bits(1);
    chk("t5_no_ff", got_q.size(), 0);
    send_frame(8'h81, 1'b1);
    idle_bits(1);
    exp_q.push_back(8'h81);
    check_stream("t5");

    // Handshake on the exact delivery cycle of the second byte
    clear_obs();
    #1 rx_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    idle_bits(1);
    chk("t6_first", {24'h0, rx_data}, 32'h11);
    n_vfall = 0;
    fork
      send_frame(8'h22, 1'b1);
      begin
        repeat (DELIVER_CLKS) @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
      end
    join
    idle_bits(1);
    chk("t6_vfall", n_vfall, 0);
    chk("t6_valid", {31'h0, rx_valid}, 32'h1);
    chk("t6_data", {24'h0, rx_data}, 32'h22);
    chk("t6_ov", n_ov, 0);
    #1 rx_ready = 1'b1;
    repeat (4) @(posedge clk);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    check_stream("t6");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Synthesizable UART receiver; the DUT-side consumer of the serial line driven by the UART agent's send_data and by the bench's byte-send task.
- Frame format: 8N1, LSB first, line idles high.
- Oversamples the line, rebuilds each byte and presents it on a valid/ready output holding register.
- Flags framing errors and overruns as single-cycle pulses.

Parameters:
- CLK_FREQ, 100_000_000: system clock frequency in Hz.
- BAUDRATE, 9600: serial bit rate.
- OVERSAMPLE, 16: sample ticks per bit. Must be even and at least 8.

Ports:
- clk  in  1: system clock, rising edge.
- rst_n  in  1: reset.
- rx  in  1: asynchronous serial input, idle high.
- rx_data  out  8: received byte, stable while rx_valid=1.
- rx_valid  out  1: byte available in the holding register.
- rx_ready  in  1: consumer accepts the byte on a cycle where rx_valid and rx_ready are both 1.
- frame_err  out  1: one-cycle pulse when the stop bit is sampled 0.
- overrun  out  1: one-cycle pulse when a good byte is dropped because the holding register is full.

Interface decision: one clock; reset is asynchronous and active-low.

Behaviour:
- Reset values: rx_data=0, rx_valid=0, frame_err=0, overrun=0, state=IDLE, synchronizer flops=1, all counters=0.
- Reset asserted mid-frame aborts the frame immediately; nothing is delivered.
- Synchronizer: 2-flop on rx, giving rx_s. All logic uses rx_s.
- Tick generator: DIV = CLK_FREQ/(BAUDRATE*OVERSAMPLE), integer-truncated, at least 1. Free-running counter 0..DIV-1; tick=1 on the wrap cycle.
- The tick counter is cleared on the IDLE to START transition so the phase aligns to the start edge.
- Sample counter: counts ticks 0..OVERSAMPLE-1. The mid-bit sample is taken at count OVERSAMPLE/2-1. The bit ends at count OVERSAMPLE-1.
- State machine:
  - IDLE: rx_s=0 → START; counters cleared.
  - START: at mid-bit, rx_s=1 → false start (glitch), back to IDLE with no flags. rx_s=0 → continue. At bit end → DATA, bit index=0.
  - DATA: at mid-bit, shift rx_s into the shift register at position bit_idx (LSB first). At bit end, bit_idx=7 → STOP, otherwise bit_idx+1.
  - STOP: at mid-bit, rx_s=1 → deliver the byte (see holding register), → IDLE. rx_s=0 → frame_err pulse, byte discarded, → BREAK.
  - BREAK: wait until rx_s=1, then → IDLE. Covers break conditions and stuck-low lines.
- Return to IDLE at the stop-bit mid-sample is intentional: it allows back-to-back frames with a short stop bit.
- Holding register, evaluated on the delivery cycle:
  - rx_valid=0: load rx_data, rx_valid=1 on the next edge.
  - rx_valid=1 and rx_ready=1 on the same cycle: consume the old byte and load the new one; rx_valid stays 1; no overrun.
  - rx_valid=1 and rx_ready=0: keep the old byte, drop the new one, pulse overrun.
  - Otherwise, rx_valid clears on the cycle after a handshake.
- Latency: rx_valid rises 2 (synchronizer) + 1 clocks after the stop-bit mid-sample, i.e. about 9.5 bit times after the falling start edge.
- Baud accuracy: truncation error must be below 2%. Elaboration fails (via $error) otherwise.

Decomposition:
- Shared package uart_pkg:
  - rx_state_t enum: IDLE, START, DATA, STOP, BREAK.
  - DATA_W=8.
  - Function calc_div(clk_freq, baud, os), reused later by uart_tx.
- One sub-module, uart_baud_tick:
  - Parameters: DIV.
  - Inputs: clk, rst_n, clear.
  - Output: tick.
  - Reused by the future transmitter.

Test Plan (CLK_FREQ=1_536_000, BAUDRATE=9600, OVERSAMPLE=16, so DIV=10 and 160 clocks per bit; rx connected to the agent's tx):
- Agent sends 0x23 with rx_ready=1 → one-cycle rx_valid with rx_data=0x23, no flags.
- rx_ready=0; send 0x51 then 0xA5 back-to-back → rx_data holds 0x51 with rx_valid=1. overrun pulses once at 0xA5's stop-bit sample. Raising rx_ready then yields 0x51 only.
- Stop bit driven 0 for the frame 0x3C, line held low 3 bit times, then 0x7E sent → frame_err pulses once, 0x3C is not delivered, 0x7E is received correctly.
- 40-clock low glitch on idle rx → no rx_valid, no frame_err; a following 0x00 frame is received correctly.
- rst_n pulsed low during data bit 4 of 0xFF, then 0x81 sent → no delivery of 0xFF; outputs at reset values; 0x81 is received.
- rx_ready toggled so that a handshake falls exactly on the delivery cycle of the second of two frames (0x11, 0x22) → both bytes are delivered in order, rx_valid never drops between them, no overrun.
